// File: rtl/slow_link_transmitter.sv
// SlowLink transmit end: frames parallel words as SYNC + DATA + even PARITY NRZ bits,
// drives a mid-bit rising bit clock, and fills gaps with an alternating idle pattern.
module slow_link_transmitter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned HALF_PERIOD = 4,
  parameter logic [7:0]  SYNC_WORD   = 8'hD5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  dout,
  output logic                  bit_clk,
  output logic                  busy
);

  localparam int unsigned CntW     = $clog2(2 * HALF_PERIOD);
  localparam int unsigned DataCntW = $clog2(DATA_WIDTH);

  localparam logic [CntW-1:0]     CntMax  = CntW'(2 * HALF_PERIOD - 1);
  localparam logic [CntW-1:0]     HalfCnt = CntW'(HALF_PERIOD);
  localparam logic [DataCntW-1:0] LastIdx = DataCntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSync, StData, StParity} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  bit_clk_q, bit_clk_d;
  logic                  dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  idle_bit_q, idle_bit_d;
  logic [2:0]            sync_idx_q, sync_idx_d;
  logic [DataCntW-1:0]   data_cnt_q, data_cnt_d;

  logic boundary;
  logic accept;
  logic start_frame;
  logic emit_idle;

  assign boundary = (cnt_q == CntMax);
  assign accept   = tx_valid & ~hold_valid_q;

  // Bit timer and bit clock; bit_clk is high for the second half of each bit.
  always_comb begin
    cnt_d     = boundary ? '0 : cnt_q + CntW'(1);
    bit_clk_d = (cnt_d >= HalfCnt);
  end

  // Holding register handshake and framing FSM; line state only moves on a boundary.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    busy_d       = busy_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    idle_bit_d   = idle_bit_q;
    sync_idx_d   = sync_idx_q;
    data_cnt_d   = data_cnt_q;
    start_frame  = 1'b0;
    emit_idle    = 1'b0;

    if (accept) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    if (boundary) begin
      unique case (state_q)
        StIdle: begin
          if (hold_valid_q) start_frame = 1'b1;
          else              emit_idle   = 1'b1;
        end
        StSync: begin
          // sync_idx_q is the marker bit currently on the line
          if (sync_idx_q == 3'd0) begin
            state_d    = StData;
            dout_d     = shift_q[DATA_WIDTH-1];
            parity_d   = parity_q ^ shift_q[DATA_WIDTH-1];
            shift_d    = shift_q << 1;
            data_cnt_d = LastIdx;
          end else begin
            sync_idx_d = sync_idx_q - 3'd1;
            dout_d     = SYNC_WORD[sync_idx_d];
          end
        end
        StData: begin
          // data_cnt_q counts payload bits still to be sent
          if (data_cnt_q == '0) begin
            state_d = StParity;
            dout_d  = parity_q;
          end else begin
            dout_d     = shift_q[DATA_WIDTH-1];
            parity_d   = parity_q ^ shift_q[DATA_WIDTH-1];
            shift_d    = shift_q << 1;
            data_cnt_d = data_cnt_q - DataCntW'(1);
          end
        end
        StParity: begin
          if (hold_valid_q) begin
            start_frame = 1'b1;
          end else begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            emit_idle = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (start_frame) begin
        state_d      = StSync;
        shift_d      = hold_q;
        hold_valid_d = 1'b0;
        dout_d       = SYNC_WORD[7];
        busy_d       = 1'b1;
        parity_d     = 1'b0;
        sync_idx_d   = 3'd7;
      end

      // Idle pattern continues from where the last gap left off
      if (emit_idle) begin
        dout_d     = idle_bit_q;
        idle_bit_d = ~idle_bit_q;
      end
    end
  end

  // State registers; reset aborts any frame and drops the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_clk_q    <= 1'b0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      idle_bit_q   <= 1'b1;
      sync_idx_q   <= '0;
      data_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_clk_q    <= bit_clk_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      idle_bit_q   <= idle_bit_d;
      sync_idx_q   <= sync_idx_d;
      data_cnt_q   <= data_cnt_d;
    end
  end

  assign tx_ready = ~hold_valid_q;
  assign dout     = dout_q;
  assign bit_clk  = bit_clk_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_slow_link_transmitter.sv
// Directed bench for slow_link_transmitter (DATA_WIDTH=16, HALF_PERIOD=4, SYNC 8'hD5).
module tb_slow_link_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        dout;
  logic        bit_clk;
  logic        busy;

  int total = 0;
  int bad   = 0;

  slow_link_transmitter #(
    .DATA_WIDTH (16),
    .HALF_PERIOD(4),
    .SYNC_WORD  (8'hD5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .dout    (dout),
    .bit_clk (bit_clk),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Check the bit on the line now, then move to the next bit boundary.
  task automatic check_bit(input string tag, input logic exp_dout, input logic exp_busy);
    check({tag, "_dout"}, dout, exp_dout);
    check({tag, "_busy"}, busy, exp_busy);
    step(8);
  endtask

  initial begin
    logic [24:0] fa;
    logic [49:0] fab;
    logic [24:0] fc;
    fa  = {8'hD5, 16'hA55A, 1'b0};
    fab = {8'hD5, 16'h0001, 1'b1, 8'hD5, 16'hFFFF, 1'b0};
    fc  = {8'hD5, 16'hC3F0, 1'b0};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_dout", dout, 1'b0);
    check("rst_bit_clk", bit_clk, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    step(3);
    rst_n = 1'b1;  // k = 0 from here

    // Idle pattern and bit clock, k = 1..16
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("idle_bit_clk", bit_clk, ((k % 8) >= 4));
      check("idle_dout", dout, logic'((k / 8) % 2));
      check("idle_ready", tx_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
    end

    // Single word 16'hA55A accepted at k=17, frame starts at k=24
    tx_valid = 1'b1;
    tx_data  = 16'hA55A;
    step(1);
    tx_valid = 1'b0;
    tx_data  = 16'h1111;
    check("a_ready_after_accept", tx_ready, 1'b0);
    check("a_busy_before", busy, 1'b0);
    step(6);
    check("a_ready_held", tx_ready, 1'b0);
    check("a_dout_before", dout, 1'b0);
    step(1);
    check("a_ready_at_start", tx_ready, 1'b1);
    for (int i = 0; i < 25; i++) check_bit("frame_a", fa[24-i], 1'b1);
    check_bit("a_idle0", 1'b1, 1'b0);
    check_bit("a_idle1", 1'b0, 1'b0);

    // Back-to-back 16'h0001 then 16'hFFFF; k = 240
    tx_valid = 1'b1;
    tx_data  = 16'h0001;
    step(1);
    tx_valid = 1'b0;
    step(7);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        tx_valid = 1'b1;
        tx_data  = 16'hFFFF;
      end
      if (i == 11) begin
        tx_valid = 1'b0;
        tx_data  = 16'h0BAD;
      end
      if (i == 20) check("b2b_ready_held", tx_ready, 1'b0);
      if (i == 25) check("b2b_ready_free", tx_ready, 1'b1);
      check_bit("frame_ab", fab[49-i], 1'b1);
    end
    check_bit("ab_idle0", 1'b0, 1'b0);
    check_bit("ab_idle1", 1'b1, 1'b0);

    // Handshake in the cnt=7 cycle (k=664 -> accept at edge 672)
    step(7);
    tx_valid = 1'b1;
    tx_data  = 16'hC3F0;
    step(1);
    tx_valid = 1'b0;
    check("late_busy", busy, 1'b0);
    check("late_ready", tx_ready, 1'b0);
    check("late_dout_idle", dout, 1'b1);
    step(8);
    check("late_ready_start", tx_ready, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        tx_valid = 1'b1;
        tx_data  = 16'h1234;
      end
      if (i == 3) begin
        tx_valid = 1'b0;
        check("c_ready_held", tx_ready, 1'b0);
      end
      check_bit("frame_c", fc[24-i], 1'b1);
    end

    // Mid-DATA reset with a word held
    step(5);
    check("pre_rst_dout", dout, 1'b1);
    check("pre_rst_bit_clk", bit_clk, 1'b1);
    check("pre_rst_ready", tx_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_dout", dout, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", tx_ready, 1'b1);
    check("abort_bit_clk", bit_clk, 1'b0);
    step(3);
    check("abort_hold_dout", dout, 1'b0);
    rst_n = 1'b1;
    check("rel_dout", dout, 1'b0);
    check("rel_bit_clk", bit_clk, 1'b0);
    for (int j = 1; j <= 30; j++) begin
      step(8);
      check("post_rst_dout", dout, logic'(j % 2));
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_ready", tx_ready, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slow_link_transmitter.md
Name: slow_link_transmitter

Overview:
- Transmit end of the SlowLink serial interface: serializes parallel words into framed NRZ bits at 1/(2*HALF_PERIOD) of clk.
- Also drives the transmit bit clock, whose rising edge sits at mid-bit.
- Emits an alternating idle pattern between frames, so the far-end Alexander-style phase detector always sees transitions.
- Sits between the local time/command logic (valid/ready source) and the link output pin.

Parameters:
- DATA_WIDTH, 16, payload bits per frame (≥2).
- HALF_PERIOD, 4, clk cycles per half bit period (≥2).
- SYNC_WORD, 8'hD5, 8-bit frame marker, sent MSB first.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_WIDTH  payload word.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; word is accepted when tx_valid & tx_ready.
- dout  output  1  serial data stream.
- bit_clk  output  1  transmit bit clock; low for the first half of each bit, high for the second.
- busy  output  1  dout is currently carrying frame bits (SYNC/DATA/PARITY).

Behaviour:
- Reset is asynchronous active-low with synchronous deassertion handled upstream. Reset values:
  - cnt=0, bit_clk=0, dout=0, tx_ready=1, busy=0, hold_valid=0, state=IDLE, idle_bit=1 (next idle bit to send).
- Bit timer:
  - cnt counts 0..2*HALF_PERIOD-1, then wraps.
  - Boundary = clock edge where cnt wraps 2H-1→0. All dout/state/busy updates happen only at a boundary.
  - dout is therefore constant for exactly 2H cycles.
  - bit_clk is a register, high exactly while cnt ∈ [H, 2H-1]; no glitches.
- First bit after reset is the idle bit 0 already on dout; the first boundary is 2H cycles after rst_n deasserts.
- Input handshake (one-entry holding register):
  - tx_ready = !hold_valid.
  - When tx_valid & tx_ready: hold ← tx_data, hold_valid←1 on the next edge.
  - A handshake on a boundary cycle is not visible to that boundary; the frame starts at a later boundary.
- FSM states IDLE, SYNC, DATA, PARITY. At each boundary:
  - IDLE, hold_valid=0: dout←idle_bit, idle_bit←!idle_bit.
  - IDLE, hold_valid=1: enter SYNC; shift←hold; hold_valid←0; dout←SYNC_WORD[7]; busy←1; parity accumulator←0.
  - SYNC: shift out SYNC_WORD[6..0]. After bit 0, next boundary enters DATA with dout←shift[MSB].
  - DATA: MSB first; each sent bit XORed into the parity accumulator. After the LSB, next boundary enters PARITY with dout←XOR of all data bits (even parity).
  - PARITY end, hold_valid=1: go directly to SYNC (back-to-back, no idle bits).
  - PARITY end, hold_valid=0: go to IDLE; dout←idle_bit; busy←0.
- Frame length = 9+DATA_WIDTH bits.
- idle_bit is not reset by frames; the idle pattern resumes where it left off.
- busy changes only at boundaries, together with dout.
- tx_ready returns high one cycle after the boundary that moves hold into the shift register, so the next word can be queued during the current frame.
- rst_n asserted mid-frame: the frame is aborted immediately. All outputs take reset values; the held word is discarded.
- tx_data changing while tx_valid=0, or after acceptance, has no effect.

Test Plan:
- Reset, DATA_WIDTH=16, H=4, no traffic:
  - bit_clk period 8 cycles, high cycles 4..7 after release.
  - dout = 0,1,0,1… changing only when cnt wraps; tx_ready=1, busy=0.
- Single word 16'hA55A:
  - dout shows 1101_0101 then 1010_0101_0101_1010, then parity 0 (8 ones), then the idle pattern.
  - busy high for exactly 25 bits (200 cycles); tx_ready low for one cycle after accept until frame start.
- Words 16'h0001 and 16'hFFFF offered back-to-back (second while the first is in DATA):
  - Frames are contiguous with no idle bits between them.
  - Parities are 1 and 0; tx_ready stays low while the second word is held.
- Handshake on the cnt=7 cycle:
  - The frame starts at the boundary 8 cycles later, not the immediate one.
- rst_n pulsed low mid-DATA:
  - dout=0, busy=0, tx_ready=1, bit_clk=0 immediately (asynchronous).
  - After release, only the idle pattern is sent; the aborted and held words never appear.
